// File: rtl/card_grid_renderer_pkg.sv
// Shared constants, stage payload types and helpers for the card grid renderer.
package card_grid_renderer_pkg;

    // Default geometry
    localparam int unsigned DEF_COLS      = 18;
    localparam int unsigned DEF_ROWS      = 8;
    localparam int unsigned DEF_CARD_W    = 32;
    localparam int unsigned DEF_CARD_H    = 55;
    localparam int unsigned DEF_X0        = 32;
    localparam int unsigned DEF_Y0        = 19;
    localparam int unsigned DEF_SPLIT_ROW = 6;
    localparam int unsigned DEF_SPLIT_GAP = 11;
    localparam int unsigned DEF_TYPE_W    = 6;
    localparam int unsigned DEF_BLINK     = 30;

    // Datapath widths
    localparam int unsigned COLOR_W     = 12;
    localparam int unsigned CNT_W       = 10;
    localparam int unsigned COL_W       = 5;
    localparam int unsigned ROW_W       = 3;
    localparam int unsigned PXY_W       = 6;
    localparam int unsigned FRAME_CNT_W = 6;

    // Pixel strobe to rendered pixel, in clocks
    localparam int unsigned PIPE_LAT = 3;

    // Card type reserved for an empty slot
    localparam int unsigned EMPTY_TYPE = 0;

    localparam logic [COLOR_W-1:0] DEF_BG_COLOR = 12'h000;
    localparam logic [COLOR_W-1:0] DEF_HL_COLOR = 12'hFF0;

    // Cell position of one pixel as produced by the locator
    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [PXY_W-1:0] px;
        logic [PXY_W-1:0] py;
        logic             in_grid;
    } loc_t;

    // Stage-1 payload: located pixel plus the highlight request sampled with it
    typedef struct packed {
        loc_t             loc;
        logic             sel_en;
        logic [COL_W-1:0] sel_col;
        logic [ROW_W-1:0] sel_row;
    } s1_t;

    // True for the two-pixel frame drawn around a highlighted card
    function automatic logic on_border(input logic [PXY_W-1:0] px,
                                       input logic [PXY_W-1:0] py,
                                       input int unsigned      card_w,
                                       input int unsigned      card_h);
        logic [31:0] x;
        logic [31:0] y;
        x = 32'(px);
        y = 32'(py);
        return (x < 32'd2) || (x >= card_w - 32'd2) ||
               (y < 32'd2) || (y >= card_h - 32'd2);
    endfunction

endpackage

// File: rtl/card_grid_renderer_grid_locator.sv
// Combinational screen-to-card mapping: column, row, in-card offset and grid hit.
module grid_locator
    import card_grid_renderer_pkg::*;
#(
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned CARD_W    = DEF_CARD_W,
    parameter int unsigned CARD_H    = DEF_CARD_H,
    parameter int unsigned X0        = DEF_X0,
    parameter int unsigned Y0        = DEF_Y0,
    parameter int unsigned SPLIT_ROW = DEF_SPLIT_ROW,
    parameter int unsigned SPLIT_GAP = DEF_SPLIT_GAP
) (
    input  logic [CNT_W-1:0] h_cnt_i,
    input  logic [CNT_W-1:0] v_cnt_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic [PXY_W-1:0] px_o,
    output logic [PXY_W-1:0] py_o,
    output logic             in_grid_o
);

    localparam int unsigned X_END   = X0 + COLS * CARD_W;
    localparam int unsigned Y_SPLIT = Y0 + SPLIT_ROW * CARD_H;
    localparam int unsigned Y1      = Y_SPLIT + SPLIT_GAP;
    localparam int unsigned Y_END   = Y1 + (ROWS - SPLIT_ROW) * CARD_H;

    logic [31:0] h_w;
    logic [31:0] v_w;
    logic [31:0] dx;
    logic [31:0] dy;
    logic        in_x;
    logic        in_up;
    logic        in_lo;

    // Lower band rows restart their vertical offset after the blank gap
    always_comb begin
        h_w       = 32'(h_cnt_i);
        v_w       = 32'(v_cnt_i);
        in_x      = (h_w >= X0) && (h_w < X_END);
        in_up     = (v_w >= Y0) && (v_w < Y_SPLIT);
        in_lo     = (v_w >= Y1) && (v_w < Y_END);
        dx        = h_w - X0;
        dy        = in_up ? (v_w - Y0) : (v_w - Y1);
        in_grid_o = in_x && (in_up || in_lo);
        col_o     = '0;
        row_o     = '0;
        px_o      = '0;
        py_o      = '0;
        if (in_grid_o) begin
            col_o = COL_W'(dx / CARD_W);
            px_o  = PXY_W'(dx % CARD_W);
            row_o = in_up ? ROW_W'(dy / CARD_H) : ROW_W'(SPLIT_ROW + dy / CARD_H);
            py_o  = PXY_W'(dy % CARD_H);
        end
    end

endmodule

// File: rtl/card_grid_renderer.sv
// Three-stage card grid pixel renderer with double-buffered map and blinking cell highlight.
module card_grid_renderer
    import card_grid_renderer_pkg::*;
#(
    parameter int unsigned          COLS         = DEF_COLS,
    parameter int unsigned          ROWS         = DEF_ROWS,
    parameter int unsigned          CARD_W       = DEF_CARD_W,
    parameter int unsigned          CARD_H       = DEF_CARD_H,
    parameter int unsigned          X0           = DEF_X0,
    parameter int unsigned          Y0           = DEF_Y0,
    parameter int unsigned          SPLIT_ROW    = DEF_SPLIT_ROW,
    parameter int unsigned          SPLIT_GAP    = DEF_SPLIT_GAP,
    parameter int unsigned          TYPE_W       = DEF_TYPE_W,
    parameter logic [COLOR_W-1:0]   BG_COLOR     = DEF_BG_COLOR,
    parameter logic [COLOR_W-1:0]   HL_COLOR     = DEF_HL_COLOR,
    parameter int unsigned          BLINK_FRAMES = DEF_BLINK
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_en,
    input  logic [CNT_W-1:0]              h_cnt,
    input  logic [CNT_W-1:0]              v_cnt,
    input  logic [ROWS*COLS*TYPE_W-1:0]   map_in,
    input  logic                          map_valid,
    output logic                          map_ready,
    input  logic                          sel_en,
    input  logic [COL_W-1:0]              sel_col,
    input  logic [ROW_W-1:0]              sel_row,
    output logic [TYPE_W-1:0]             rom_type,
    output logic [PXY_W-1:0]              rom_x,
    output logic [PXY_W-1:0]              rom_y,
    input  logic [COLOR_W-1:0]            rom_data,
    output logic [COLOR_W-1:0]            card_pixel,
    output logic                          pixel_valid,
    output logic                          in_card
);

    localparam int unsigned MAP_W  = ROWS * COLS * TYPE_W;
    localparam int unsigned MAP_AW = $clog2(MAP_W);

    // Map buffers and frame state
    logic [MAP_W-1:0]       active_q, active_d;
    logic [MAP_W-1:0]       pend_q, pend_d;
    logic                   pend_full_q, pend_full_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   blink_q, blink_d;

    // Pipeline
    logic [PIPE_LAT-1:0]    vld_q, vld_d;
    loc_t                   loc_c;
    s1_t                    s1_q, s1_d;
    logic [TYPE_W-1:0]      rom_type_q, rom_type_d;
    logic [PXY_W-1:0]       rom_x_q, rom_x_d;
    logic [PXY_W-1:0]       rom_y_q, rom_y_d;
    logic                   s2_in_card_q, s2_in_card_d;
    logic                   s2_hl_q, s2_hl_d;
    logic [COLOR_W-1:0]     card_pixel_q, card_pixel_d;
    logic                   in_card_q, in_card_d;

    // Decode and lookup helpers
    logic                   frame_start_c;
    logic                   map_acc_c;
    logic [31:0]            slot_idx_c;
    logic [MAP_AW-1:0]      bit_base_c;
    logic [TYPE_W-1:0]      slot_type_c;
    logic                   sel_hit_c;

    grid_locator #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .CARD_W    (CARD_W),
        .CARD_H    (CARD_H),
        .X0        (X0),
        .Y0        (Y0),
        .SPLIT_ROW (SPLIT_ROW),
        .SPLIT_GAP (SPLIT_GAP)
    ) u_locator (
        .h_cnt_i   (h_cnt),
        .v_cnt_i   (v_cnt),
        .col_o     (loc_c.col),
        .row_o     (loc_c.row),
        .px_o      (loc_c.px),
        .py_o      (loc_c.py),
        .in_grid_o (loc_c.in_grid)
    );

    // Frame-start strobe and map handshake acceptance
    always_comb begin
        frame_start_c = pix_en && (h_cnt == '0) && (v_cnt == '0);
        map_acc_c     = map_valid && !pend_full_q;
    end

    // Pending buffer fills via handshake; it becomes active only at a frame start
    always_comb begin
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (frame_start_c && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end
        if (map_acc_c) begin
            pend_d      = map_in;
            pend_full_d = 1'b1;
        end
    end

    // Frame counter toggles the blink phase every BLINK_FRAMES frame starts
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (BLINK_FRAMES == 0) begin
            frame_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (frame_start_c) begin
            if (frame_cnt_q == FRAME_CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = !blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end
        end
    end

    // Stage 1: capture located pixel and highlight request on the strobe
    always_comb begin
        vld_d = {vld_q[PIPE_LAT-2:0], pix_en};
        s1_d  = s1_q;
        if (pix_en) begin
            s1_d.loc     = loc_c;
            s1_d.sel_en  = sel_en;
            s1_d.sel_col = sel_col;
            s1_d.sel_row = sel_row;
        end
    end

    // Stage 2: active-map type lookup, ROM address and highlight decision
    always_comb begin
        slot_idx_c   = 32'(s1_q.loc.row) * COLS + 32'(s1_q.loc.col);
        bit_base_c   = MAP_AW'(slot_idx_c * TYPE_W);
        slot_type_c  = active_q[bit_base_c +: TYPE_W];
        sel_hit_c    = s1_q.sel_en &&
                       (32'(s1_q.sel_col) < COLS) && (32'(s1_q.sel_row) < ROWS) &&
                       (s1_q.sel_col == s1_q.loc.col) && (s1_q.sel_row == s1_q.loc.row);
        rom_type_d   = rom_type_q;
        rom_x_d      = rom_x_q;
        rom_y_d      = rom_y_q;
        s2_in_card_d = s2_in_card_q;
        s2_hl_d      = s2_hl_q;
        if (vld_q[0]) begin
            rom_type_d   = s1_q.loc.in_grid ? slot_type_c : TYPE_W'(EMPTY_TYPE);
            rom_x_d      = s1_q.loc.px;
            rom_y_d      = s1_q.loc.py;
            s2_in_card_d = s1_q.loc.in_grid && (slot_type_c != TYPE_W'(EMPTY_TYPE));
            s2_hl_d      = s1_q.loc.in_grid && sel_hit_c && blink_q &&
                           on_border(s1_q.loc.px, s1_q.loc.py, CARD_W, CARD_H);
        end
    end

    // Stage 3: choose highlight, ROM pixel or background
    always_comb begin
        card_pixel_d = card_pixel_q;
        in_card_d    = in_card_q;
        if (vld_q[1]) begin
            in_card_d = s2_in_card_q;
            if (s2_hl_q) begin
                card_pixel_d = HL_COLOR;
            end else if (s2_in_card_q) begin
                card_pixel_d = rom_data;
            end else begin
                card_pixel_d = BG_COLOR;
            end
        end
    end

    // State and pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b1;
            vld_q        <= '0;
            s1_q         <= '0;
            rom_type_q   <= '0;
            rom_x_q      <= '0;
            rom_y_q      <= '0;
            s2_in_card_q <= 1'b0;
            s2_hl_q      <= 1'b0;
            card_pixel_q <= BG_COLOR;
            in_card_q    <= 1'b0;
        end else begin
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            vld_q        <= vld_d;
            s1_q         <= s1_d;
            rom_type_q   <= rom_type_d;
            rom_x_q      <= rom_x_d;
            rom_y_q      <= rom_y_d;
            s2_in_card_q <= s2_in_card_d;
            s2_hl_q      <= s2_hl_d;
            card_pixel_q <= card_pixel_d;
            in_card_q    <= in_card_d;
        end
    end

    assign map_ready   = !pend_full_q;
    assign rom_type    = rom_type_q;
    assign rom_x       = rom_x_q;
    assign rom_y       = rom_y_q;
    assign card_pixel  = card_pixel_q;
    assign in_card     = in_card_q;
    assign pixel_valid = vld_q[PIPE_LAT-1];

endmodule

// File: tb/tb_card_grid_renderer.sv
// Directed bench for card_grid_renderer: geometry, map double buffering, blink highlight, reset.
module tb_card_grid_renderer;

    localparam int unsigned MAP_W = 8 * 18 * 6;

    logic             clk;
    logic             rst;
    logic             pix_en;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [MAP_W-1:0] map_in;
    logic             map_valid;
    logic             map_ready;
    logic             sel_en;
    logic [4:0]       sel_col;
    logic [2:0]       sel_row;
    logic [5:0]       rom_type;
    logic [5:0]       rom_x;
    logic [5:0]       rom_y;
    logic [11:0]      rom_data;
    logic [11:0]      card_pixel;
    logic             pixel_valid;
    logic             in_card;

    int total;
    int bad;

    logic [5:0]       r_type;
    logic [5:0]       r_x;
    logic [5:0]       r_y;
    logic [MAP_W-1:0] m;

    card_grid_renderer #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .map_in      (map_in),
        .map_valid   (map_valid),
        .map_ready   (map_ready),
        .sel_en      (sel_en),
        .sel_col     (sel_col),
        .sel_row     (sel_row),
        .rom_type    (rom_type),
        .rom_x       (rom_x),
        .rom_y       (rom_y),
        .rom_data    (rom_data),
        .card_pixel  (card_pixel),
        .pixel_valid (pixel_valid),
        .in_card     (in_card)
    );

    // Card ROM model: pixel word shows type, x and y nibbles
    assign rom_data = {rom_type[3:0], rom_x[3:0], rom_y[3:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int h, input int v);
        pix_en = 1'b1;
        h_cnt  = 10'(h);
        v_cnt  = 10'(v);
    endtask

    // One pixel through the pipe; ROM address captured at S2, ends with S3 visible
    task automatic pix3(input int h, input int v);
        set_pix(h, v);
        step();
        pix_en = 1'b0;
        step();
        r_type = rom_type;
        r_x    = rom_x;
        r_y    = rom_y;
        step();
    endtask

    task automatic load_map(input logic [MAP_W-1:0] mm);
        map_in    = mm;
        map_valid = 1'b1;
        step();
        map_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        total++; if (map_ready !== 1'b1) begin bad++; $display("FAIL reset_map_ready: got %b want 1", map_ready); end
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset_pv: got %b want 0", pixel_valid); end
        total++; if (in_card !== 1'b0) begin bad++; $display("FAIL reset_in_card: got %b want 0", in_card); end
        total++; if (card_pixel !== 12'h000) begin bad++; $display("FAIL reset_pixel: got %h want 000", card_pixel); end
        total++; if ({rom_type, rom_x, rom_y} !== 18'h0) begin bad++; $display("FAIL reset_rom_addr: got %h want 0", {rom_type, rom_x, rom_y}); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_empty();
        set_pix(32, 19);
        step();
        pix_en = 1'b0;
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL empty_pv_c1: got %b want 0", pixel_valid); end
        step();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL empty_pv_c2: got %b want 0", pixel_valid); end
        step();
        total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL empty_pv_c3: got %b want 1", pixel_valid); end
        total++; if (in_card !== 1'b0) begin bad++; $display("FAIL empty_in_card: got %b want 0", in_card); end
        total++; if (card_pixel !== 12'h000) begin bad++; $display("FAIL empty_pixel: got %h want 000", card_pixel); end
        step();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL empty_pv_c4: got %b want 0", pixel_valid); end
    endtask

    task automatic test_lookup();
        m = '0;
        m[20*6 +: 6]  = 6'd5;
        m[108*6 +: 6] = 6'd9;
        load_map(m);
        pix3(0, 0);
        pix3(100, 80);
        total++; if (r_type !== 6'd5) begin bad++; $display("FAIL lookup_type: got %0d want 5", r_type); end
        total++; if (r_x !== 6'd4) begin bad++; $display("FAIL lookup_x: got %0d want 4", r_x); end
        total++; if (r_y !== 6'd6) begin bad++; $display("FAIL lookup_y: got %0d want 6", r_y); end
        total++; if (card_pixel !== 12'h546) begin bad++; $display("FAIL lookup_pixel: got %h want 546", card_pixel); end
        total++; if (in_card !== 1'b1) begin bad++; $display("FAIL lookup_in_card: got %b want 1", in_card); end
        total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL lookup_pv: got %b want 1", pixel_valid); end
    endtask

    task automatic test_gap();
        pix3(32, 350);
        total++; if (in_card !== 1'b0) begin bad++; $display("FAIL gap_in_card: got %b want 0", in_card); end
        total++; if (card_pixel !== 12'h000) begin bad++; $display("FAIL gap_pixel: got %h want 000", card_pixel); end
        pix3(32, 360);
        total++; if (r_type !== 6'd9) begin bad++; $display("FAIL band_type: got %0d want 9", r_type); end
        total++; if ({r_x, r_y} !== 12'h000) begin bad++; $display("FAIL band_xy: got x=%0d y=%0d want 0 0", r_x, r_y); end
        total++; if (card_pixel !== 12'h900) begin bad++; $display("FAIL band_pixel: got %h want 900", card_pixel); end
        pix3(32, 349);
        total++; if (in_card !== 1'b0) begin bad++; $display("FAIL gap_first_line: got %b want 0", in_card); end
        pix3(607, 80);
        total++; if (r_x !== 6'd31) begin bad++; $display("FAIL right_edge_x: got %0d want 31", r_x); end
        pix3(608, 80);
        total++; if (in_card !== 1'b0) begin bad++; $display("FAIL right_out: got %b want 0", in_card); end
    endtask

    task automatic test_double_buffer();
        logic [MAP_W-1:0] m2;
        total++; if (map_ready !== 1'b1) begin bad++; $display("FAIL db_ready_idle: got %b want 1", map_ready); end
        m2 = m;
        m2[20*6 +: 6] = 6'd3;
        load_map(m2);
        total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL db_ready_full: got %b want 0", map_ready); end
        m2[20*6 +: 6] = 6'd1;
        load_map(m2);
        total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL db_second_load: got %b want 0", map_ready); end
        pix3(100, 80);
        total++; if (r_type !== 6'd5) begin bad++; $display("FAIL db_mid_frame: got %0d want 5", r_type); end
        pix3(0, 0);
        total++; if (map_ready !== 1'b1) begin bad++; $display("FAIL db_commit_ready: got %b want 1", map_ready); end
        pix3(100, 80);
        total++; if (r_type !== 6'd3) begin bad++; $display("FAIL db_committed: got %0d want 3", r_type); end
        total++; if (card_pixel !== 12'h346) begin bad++; $display("FAIL db_pixel: got %h want 346", card_pixel); end
        // Map accepted on the frame-start cycle waits for the following frame start
        m2[20*6 +: 6] = 6'd2;
        map_in    = m2;
        map_valid = 1'b1;
        set_pix(0, 0);
        step();
        map_valid = 1'b0;
        pix_en    = 1'b0;
        total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL db_fs_accept: got %b want 0", map_ready); end
        step();
        step();
        pix3(100, 80);
        total++; if (r_type !== 6'd3) begin bad++; $display("FAIL db_fs_not_yet: got %0d want 3", r_type); end
        pix3(0, 0);
        pix3(100, 80);
        total++; if (r_type !== 6'd2) begin bad++; $display("FAIL db_fs_next: got %0d want 2", r_type); end
    endtask

    task automatic test_blink();
        logic [MAP_W-1:0] mb;
        rst = 1'b0;
        step();
        rst = 1'b1;
        sel_en  = 1'b1;
        sel_col = 5'd0;
        sel_row = 3'd0;
        // Frame 0 (before any frame start): empty slot still highlights
        pix3(32, 19);
        total++; if (card_pixel !== 12'hFF0) begin bad++; $display("FAIL blink_f0_hl: got %h want ff0", card_pixel); end
        total++; if (in_card !== 1'b0) begin bad++; $display("FAIL blink_f0_in_card: got %b want 0", in_card); end
        mb = '0;
        mb[0 +: 6] = 6'd7;
        load_map(mb);
        // Frame 1
        pix3(0, 0);
        pix3(32, 19);
        total++; if (card_pixel !== 12'hFF0) begin bad++; $display("FAIL blink_f1_hl: got %h want ff0", card_pixel); end
        total++; if (in_card !== 1'b1) begin bad++; $display("FAIL blink_f1_in_card: got %b want 1", in_card); end
        pix3(37, 24);
        total++; if (card_pixel !== 12'h755) begin bad++; $display("FAIL blink_f1_inner: got %h want 755", card_pixel); end
        pix3(32, 72);
        total++; if (card_pixel !== 12'hFF0) begin bad++; $display("FAIL blink_f1_bottom: got %h want ff0", card_pixel); end
        // Frame 2
        pix3(0, 0);
        pix3(32, 19);
        total++; if (card_pixel !== 12'h700) begin bad++; $display("FAIL blink_f2_off: got %h want 700", card_pixel); end
        // Frame 3
        pix3(0, 0);
        pix3(32, 19);
        total++; if (card_pixel !== 12'h700) begin bad++; $display("FAIL blink_f3_off: got %h want 700", card_pixel); end
        // Frame 4
        pix3(0, 0);
        pix3(32, 19);
        total++; if (card_pixel !== 12'hFF0) begin bad++; $display("FAIL blink_f4_hl: got %h want ff0", card_pixel); end
        sel_col = 5'd20;
        pix3(32, 19);
        total++; if (card_pixel !== 12'h700) begin bad++; $display("FAIL blink_sel_range: got %h want 700", card_pixel); end
        sel_col = 5'd1;
        pix3(32, 19);
        total++; if (card_pixel !== 12'h700) begin bad++; $display("FAIL blink_other_cell: got %h want 700", card_pixel); end
        sel_en  = 1'b0;
        sel_col = 5'd0;
    endtask

    task automatic test_reset_mid();
        load_map(m);
        total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL rm_pend_full: got %b want 0", map_ready); end
        set_pix(32, 19);
        step();
        set_pix(33, 19);
        step();
        set_pix(34, 19);
        rst = 1'b0;
        step();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL rm_pv_reset: got %b want 0", pixel_valid); end
        rst    = 1'b1;
        pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL rm_pv_idle%0d: got %b want 0", i, pixel_valid); end
        end
        total++; if (map_ready !== 1'b1) begin bad++; $display("FAIL rm_map_ready: got %b want 1", map_ready); end
        set_pix(32, 19);
        step();
        pix_en = 1'b0;
        step();
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL rm_pv_c2: got %b want 0", pixel_valid); end
        step();
        total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL rm_pv_c3: got %b want 1", pixel_valid); end
        total++; if (in_card !== 1'b0) begin bad++; $display("FAIL rm_map_cleared: got %b want 0", in_card); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        pix_en    = 1'b0;
        h_cnt     = '0;
        v_cnt     = '0;
        map_in    = '0;
        map_valid = 1'b0;
        sel_en    = 1'b0;
        sel_col   = '0;
        sel_row   = '0;
        m         = '0;
        test_reset();
        test_empty();
        test_lookup();
        test_gap();
        test_double_buffer();
        test_blink();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/card_grid_renderer.md
CARD_GRID_RENDERER -- requirements
Module: card_grid_renderer

Interface
REQ-001 Parameter COLS, default 18, sets the number of card columns.
REQ-002 Parameter ROWS, default 8, sets the number of card rows.
REQ-003 Parameters CARD_W and CARD_H, defaults 32 and 55, set the card size in pixels.
REQ-004 Parameters X0 and Y0, defaults 32 and 19, set the top-left pixel of row 0 / column 0.
REQ-005 Parameters SPLIT_ROW and SPLIT_GAP, defaults 6 and 11, insert SPLIT_GAP blank lines above row SPLIT_ROW (the hand band).
REQ-006 Parameter TYPE_W, default 6, sets the card-type width; type 0 means empty slot.
REQ-007 Parameters BG_COLOR, HL_COLOR and BLINK_FRAMES, defaults 12'h000, 12'hFF0 and 30, set background colour, highlight colour and blink half-period in frames.
REQ-008 clk  in  1  single system clock.
REQ-009 rst  in  1  reset, synchronous and active-low.
REQ-010 pix_en  in  1  pixel strobe; h_cnt and v_cnt are sampled only when it is high.
REQ-011 h_cnt, v_cnt  in  10 each  VGA pixel coordinates.
REQ-012 map_in  in  ROWS*COLS*TYPE_W  new map; slot i = row*COLS+col occupies bits [i*TYPE_W +: TYPE_W].
REQ-013 map_valid / map_ready  in / out  1 each  map-load handshake.
REQ-014 sel_en, sel_col, sel_row  in  1, 5, 3  selected-cell highlight request.
REQ-015 rom_type, rom_x, rom_y  out  TYPE_W, 6, 6  card-ROM address.
REQ-016 rom_data  in  12  ROM pixel, valid exactly 1 clk after the address.
REQ-017 card_pixel, pixel_valid, in_card  out  12, 1, 1  rendered pixel, strobe and inside-card flag.

Function
REQ-018 A pixel is in the grid when X0 <= h_cnt < X0+COLS*CARD_W and v_cnt lies in the upper band [Y0, Y0+SPLIT_ROW*CARD_H) or the lower band [Y1, Y1+(ROWS-SPLIT_ROW)*CARD_H), where Y1 = Y0+SPLIT_ROW*CARD_H+SPLIT_GAP.
REQ-019 For an in-grid pixel: col = (h_cnt-X0)/CARD_W and px = (h_cnt-X0) mod CARD_W; in the upper band row = (v_cnt-Y0)/CARD_H, in the lower band row = SPLIT_ROW+(v_cnt-Y1)/CARD_H; py is the remainder of the same division.
REQ-020 Three-stage pipeline: S1 registers col, row, px, py and in-grid; S2 registers the type lookup and drives rom_type, rom_x, rom_y; S3 registers card_pixel; pixel_valid is pix_en delayed exactly 3 clk.
REQ-021 The pipeline advances every clk; stages holding no valid pixel keep their data but are marked invalid.
REQ-022 card_pixel = BG_COLOR and in_card = 0 for any out-of-grid pixel or a type-0 slot; otherwise in_card = 1.
REQ-023 Highlight: when sel_en, the cell equals (sel_col, sel_row) and blink_on, pixels with px<2, px>=CARD_W-2, py<2 or py>=CARD_H-2 output HL_COLOR (this applies to empty slots as well); all other in-card pixels output rom_data.
REQ-024 sel_en, sel_col and sel_row are sampled in S1 together with h_cnt.
REQ-025 Frame start is pix_en with h_cnt==0 and v_cnt==0; a 6-bit frame counter counts frame starts, wraps at BLINK_FRAMES-1 and toggles blink_on on wrap.
REQ-026 When BLINK_FRAMES==0, blink_on is held at 1.
REQ-027 Double buffer: map_ready = ~pend_full; map_valid & map_ready copies map_in into the pending buffer and sets pend_full.
REQ-028 At frame start with pend_full, the pending buffer is copied into the active map and pend_full is cleared.
REQ-029 The type lookup always reads the active map, so the active map never changes mid-frame.
REQ-030 A map accepted in the same cycle as a frame start commits at the next frame start.
REQ-031 sel_col >= COLS or sel_row >= ROWS never highlights.

Reset
REQ-032 While rst==0 at a clk edge: active map and pending buffer cleared to 0, pend_full=0 (map_ready=1), frame counter=0, blink_on=1, all pipeline valid bits=0, card_pixel=BG_COLOR, pixel_valid=0, in_card=0, rom_type/rom_x/rom_y=0.
REQ-033 Reset mid-frame discards all in-flight pixels; the first pixel_valid occurs 3 clk after the first pix_en following release.

Structure
REQ-034 A shared package holds default geometry constants, the type-0 EMPTY code, the colour width (12) and the pipeline latency constant (3).
REQ-035 A single sub-module, grid_locator (combinational h/v to col/row/px/py/in-grid), is instantiated in S1.

Verification
REQ-036 Defaults, empty-map reset, h=32, v=19 -> 3 clk later pixel_valid=1, in_card=0, card_pixel=000.
REQ-037 Map with slot(1,2)=5, h=100, v=80 -> rom_type=5, rom_x=4, rom_y=6 at S2; card_pixel=rom_data one clk later.
REQ-038 v=350 (gap line) -> in_card=0 and BG; v=360, h=32 -> row 6, py 0.
REQ-039 Load map mid-frame, then load a second map -> map_ready=0 on the second load; the display changes only after the next h=0/v=0 pix_en.
REQ-040 sel_en at (0,0), BLINK_FRAMES=2, pixel h=32, v=19 -> HL_COLOR in frames 0-1 and rom_data in frames 2-3.
REQ-041 Assert rst at the third pixel of a burst -> no pixel_valid until 3 clk after the post-reset pix_en; map_ready=1.
